// File: rtl/cfg_uart_pkg.sv
// Shared state encoding and frame constants for the cfg_master configuration UART.
package cfg_uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;
    localparam int   TX_BYTES  = 3;
    localparam int   RX_BYTES  = 2;

endpackage

// File: rtl/uart_rx8.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-clock byte_vld pulse.
module uart_rx8
    import cfg_uart_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_vld,
    output logic [7:0] rx_byte
);

    localparam logic [15:0] FULL_LAST = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

    logic        sync_p0, sync_p1, rx_prev;
    uart_state_t state, state_nxt;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        half_done, full_done, fall;

    assign half_done = (baud_cnt == HALF_LAST);
    assign full_done = (baud_cnt == FULL_LAST);
    assign fall      = rx_prev & ~sync_p1;

    // Synchroniser stage boundary; the line idles high, so all flops reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync_p0 <= rx;
            sync_p1 <= sync_p0;
            rx_prev <= sync_p1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (fall) state_nxt = START;
            START: if (half_done) state_nxt = (sync_p1 == START_BIT) ? DATA : IDLE;
            DATA:  if (full_done && bit_cnt == 3'(DATA_BITS - 1)) state_nxt = STOP;
            STOP:  if (full_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            byte_vld <= 1'b0;
            rx_byte  <= '0;
        end else begin
            byte_vld <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
                START: baud_cnt <= half_done ? 16'd0 : baud_cnt + 16'd1;
                DATA: begin
                    if (full_done) begin
                        baud_cnt <= '0;
                        bit_cnt  <= bit_cnt + 3'd1;
                        shreg    <= {sync_p1, shreg[7:1]};
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (full_done) begin
                        baud_cnt <= '0;
                        // A low stop bit is a framing error: the byte is silently dropped.
                        if (sync_p1 == STOP_BIT) begin
                            byte_vld <= 1'b1;
                            rx_byte  <= shreg;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: baud_cnt <= '0;
            endcase
        end
    end

endmodule

// File: rtl/cfg_master.sv
// Configuration master: sends a 24-bit word as three 8N1 bytes and assembles a two-byte response.
module cfg_master
    import cfg_uart_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] cmd_data,
    input  logic        initiate,
    output logic        TX_C,
    input  logic        RX_C,
    output logic [15:0] rsp,
    output logic        rsp_rdy
);

    localparam logic [15:0] FULL_LAST = 16'(BAUD_DIV - 1);

    // The reset port is active-high despite its name.
    logic rst;
    assign rst = rst_n;

    uart_state_t tx_state, tx_state_nxt;
    logic [15:0] tx_baud;
    logic [2:0]  tx_bit_cnt;
    logic [1:0]  tx_byte_cnt;
    logic [23:0] tx_shift;
    logic [7:0]  tx_byte;
    logic        tx_full_done, tx_more, tx_accept, tx_line;

    logic       rx_vld;
    logic [7:0] rx_byte;
    logic       rx_cnt;
    logic [7:0] rx_held;
    logic       rx_last;

    assign tx_byte      = tx_shift[23:16];
    assign tx_full_done = (tx_baud == FULL_LAST);
    assign tx_more      = (tx_byte_cnt < 2'(TX_BYTES - 1));
    assign tx_accept    = (tx_state == IDLE) && initiate;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tx_state <= IDLE;
        else     tx_state <= tx_state_nxt;
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_line      = STOP_BIT;
        case (tx_state)
            IDLE: if (initiate) tx_state_nxt = START;
            START: begin
                tx_line = START_BIT;
                if (tx_full_done) tx_state_nxt = DATA;
            end
            DATA: begin
                tx_line = tx_byte[tx_bit_cnt];
                if (tx_full_done && tx_bit_cnt == 3'(DATA_BITS - 1)) tx_state_nxt = STOP;
            end
            STOP: if (tx_full_done) tx_state_nxt = tx_more ? START : IDLE;
            default: tx_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_baud     <= '0;
            tx_bit_cnt  <= '0;
            tx_byte_cnt <= '0;
            tx_shift    <= '0;
        end else if (tx_accept) begin
            tx_shift    <= cmd_data;
            tx_byte_cnt <= '0;
            tx_baud     <= '0;
            tx_bit_cnt  <= '0;
        end else if (tx_state != IDLE) begin
            if (tx_full_done) begin
                tx_baud <= '0;
                if (tx_state == DATA) tx_bit_cnt <= tx_bit_cnt + 3'd1;
                if (tx_state == STOP && tx_more) begin
                    tx_byte_cnt <= tx_byte_cnt + 2'd1;
                    tx_shift    <= {tx_shift[15:0], 8'h00};
                end
            end else begin
                tx_baud <= tx_baud + 16'd1;
            end
        end
    end

    // Line register stage boundary: TX_C follows the state by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) TX_C <= 1'b1;
        else     TX_C <= tx_line;
    end

    uart_rx8 #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (RX_C),
        .byte_vld (rx_vld),
        .rx_byte  (rx_byte)
    );

    assign rx_last = (rx_cnt == 1'(RX_BYTES - 1));

    // A completing response beats a same-edge initiate for rsp_rdy; the count still clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp     <= '0;
            rsp_rdy <= 1'b0;
            rx_cnt  <= 1'b0;
            rx_held <= '0;
        end else begin
            if (rx_vld) begin
                if (!rx_last) begin
                    rx_held <= rx_byte;
                    rx_cnt  <= 1'b1;
                end else begin
                    rsp     <= {rx_held, rx_byte};
                    rsp_rdy <= 1'b1;
                    rx_cnt  <= 1'b0;
                end
            end
            if (tx_accept) begin
                rx_cnt <= 1'b0;
                if (!(rx_vld && rx_last)) rsp_rdy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cfg_master.sv
// Self-checking bench for cfg_master: behavioural UART model, TX line decoder and randomized traffic.
module tb_cfg_master;

    localparam int B = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] cmd_data = '0;
    logic        initiate = 1'b0;
    logic        RX_C = 1'b1;
    logic        TX_C;
    logic [15:0] rsp;
    logic        rsp_rdy;

    cfg_master #(.BAUD_DIV(B)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_data (cmd_data),
        .initiate (initiate),
        .TX_C     (TX_C),
        .RX_C     (RX_C),
        .rsp      (rsp),
        .rsp_rdy  (rsp_rdy)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model state
    logic [15:0] m_rsp = '0;
    logic        m_rdy = 1'b0;
    int          m_cnt = 0;
    logic [7:0]  m_held = '0;
    longint      tx_free = 0;
    logic [7:0]  tx_exp[$];
    logic [9:0]  tx_got[$];
    bit          chk_en = 1'b1;
    bit          mon_go = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst_n) begin
            checks++;
            if ({rsp_rdy, rsp} !== {m_rdy, m_rsp}) begin
                errors++;
                $display("FAIL rsp_track cycle %0d: got rdy=%0b rsp=%h expected rdy=%0b rsp=%h",
                         cyc, rsp_rdy, rsp, m_rdy, m_rsp);
            end
        end
    end

    // TX line decoder: records {stop, data, start} for every frame seen on TX_C.
    initial begin
        wait (mon_go);
        forever begin
            logic [9:0] f;
            @(negedge TX_C);
            repeat (B / 2) @(posedge clk);
            #1 f[0] = TX_C;
            for (int i = 0; i < 8; i++) begin
                repeat (B) @(posedge clk);
                #1 f[i+1] = TX_C;
            end
            repeat (B) @(posedge clk);
            #1 f[9] = TX_C;
            tx_got.push_back(f);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic pulse_init(input logic [23:0] c);
        @(negedge clk);
        cmd_data = c;
        initiate = 1'b1;
        @(posedge clk);
        #1;
        if (cyc >= tx_free) begin
            tx_free = cyc + 30 * B + 1;
            tx_exp.push_back(c[23:16]);
            tx_exp.push_back(c[15:8]);
            tx_exp.push_back(c[7:0]);
            m_rdy = 1'b0;
            m_cnt = 0;
        end
        initiate = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok);
        chk_en = 1'b0;
        @(negedge clk);
        RX_C = 1'b0;
        repeat (B) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX_C = b[i];
            repeat (B) @(negedge clk);
        end
        RX_C = ok;
        repeat (B) @(negedge clk);
        RX_C = 1'b1;
        if (!ok) repeat (B) @(negedge clk);
        repeat (2) @(negedge clk);
        if (ok) begin
            if (m_cnt == 0) begin
                m_held = b;
                m_cnt  = 1;
            end else begin
                m_rsp = {m_held, b};
                m_rdy = 1'b1;
                m_cnt = 0;
            end
        end
        chk_en = 1'b1;
    endtask

    task automatic glitch();
        @(negedge clk);
        RX_C = 1'b0;
        repeat (4) @(negedge clk);
        RX_C = 1'b1;
        repeat (2 * B) @(negedge clk);
    endtask

    task automatic wait_tx_idle();
        int n;
        n = 0;
        while (cyc < tx_free + 2 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 5000) begin
            checks++;
            errors++;
            $display("FAIL tx_idle_timeout: got busy expected idle");
        end
    endtask

    task automatic compare_tx(input string tag);
        while (tx_exp.size() > 0) begin
            logic [7:0] e;
            e = tx_exp.pop_front();
            if (tx_got.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_missing: got no frame expected byte %h", tag, e);
            end else begin
                chk(tag, 32'(tx_got.pop_front()), 32'({1'b1, e, 1'b0}));
            end
        end
        chk({tag, "_extra"}, 32'(tx_got.size()), 32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("reset_tx", 32'(TX_C), 32'd1);
        chk("reset_rsp", 32'(rsp), 32'h0000);
        chk("reset_rdy", 32'(rsp_rdy), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        mon_go = 1'b1;
        repeat (3) @(posedge clk);

        // Send with exact timing, busy ignore, and the 481-cycle re-accept boundary
        pulse_init(24'hA5_3C_0F);
        chk("tx_latency_hold", 32'(TX_C), 32'd1);
        @(posedge clk); #1;
        chk("tx_first_fall", 32'(TX_C), 32'd0);
        repeat (15) @(posedge clk); #1;
        chk("tx_start_end", 32'(TX_C), 32'd0);
        @(posedge clk); #1;
        chk("tx_bit0", 32'(TX_C), 32'd1);
        repeat (200) @(posedge clk);
        pulse_init(24'hFF_FF_FF);
        repeat (261) @(posedge clk);
        pulse_init(24'hFF_FF_FF);
        pulse_init(24'h5A_C3_81);
        chk("tx_gap_high", 32'(TX_C), 32'd1);
        @(posedge clk); #1;
        chk("tx_restart", 32'(TX_C), 32'd0);
        wait_tx_idle();
        chk("tx_byte0", 32'(tx_got[0]), 32'({1'b1, 8'hA5, 1'b0}));
        chk("tx_byte1", 32'(tx_got[1]), 32'({1'b1, 8'h3C, 1'b0}));
        chk("tx_byte2", 32'(tx_got[2]), 32'({1'b1, 8'h0F, 1'b0}));
        compare_tx("tx_directed");

        // Response assembly and clear-on-initiate
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        chk("rsp_1234", 32'(rsp), 32'h1234);
        chk("rdy_set", 32'(rsp_rdy), 32'd1);
        pulse_init(24'h00_00_00);
        chk("rdy_cleared", 32'(rsp_rdy), 32'd0);
        chk("rsp_kept", 32'(rsp), 32'h1234);
        wait_tx_idle();
        compare_tx("tx_zero");

        // Framing error and glitch rejection
        send_byte(8'h9A, 1'b0);
        send_byte(8'h56, 1'b1);
        glitch();
        send_byte(8'h78, 1'b1);
        chk("rsp_5678", 32'(rsp), 32'h5678);
        chk("rdy_5678", 32'(rsp_rdy), 32'd1);

        // Half-received response discarded by an initiate
        send_byte(8'hAB, 1'b1);
        pulse_init(24'h12_34_56);
        send_byte(8'hCD, 1'b1);
        send_byte(8'hEF, 1'b1);
        chk("rsp_cdef", 32'(rsp), 32'hCDEF);
        wait_tx_idle();
        compare_tx("tx_discard");

        // Randomized full-duplex traffic
        for (int it = 0; it < 8; it++) begin
            fork
                begin
                    pulse_init(24'($urandom));
                    if ($urandom_range(0, 1) == 1) begin
                        repeat ($urandom_range(5, 400)) @(posedge clk);
                        pulse_init(24'($urandom));
                    end
                end
                begin
                    int nb;
                    nb = $urandom_range(0, 3);
                    for (int k = 0; k < nb; k++) begin
                        send_byte(8'($urandom), $urandom_range(0, 3) != 0);
                        if ($urandom_range(0, 3) == 0) glitch();
                    end
                end
            join
            wait_tx_idle();
            compare_tx("tx_random");
        end

        // Reset in the middle of a frame
        pulse_init(24'h00_00_00);
        repeat (20) @(posedge clk);
        #3;
        chk("tx_low_pre_reset", 32'(TX_C), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("async_reset_tx", 32'(TX_C), 32'd1);
        chk("async_reset_rsp", 32'(rsp), 32'h0000);
        chk("async_reset_rdy", 32'(rsp_rdy), 32'd0);
        m_rsp = '0;
        m_rdy = 1'b0;
        m_cnt = 0;
        tx_free = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (10) @(posedge clk);
            #1 chk("tx_idle_after_reset", 32'(TX_C), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfg_master.md
Name: cfg_master

Overview:
- Bench-side configuration master for the cbc_dig configuration UART.
- On request, serialises a 24-bit command/data word as three UART bytes on TX_C.
- Collects the DUT's two-byte response from RX_C and presents it as a 16-bit word with a ready flag.
- Sits beside cbc_dig: its TX_C drives the DUT's RX_C, and its RX_C is driven by the DUT's TX_C.

Parameters:
- BAUD_DIV, 2604: clock cycles per UART bit. Legal range is 4 to 65535.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-high. rst_n=1 resets the block, despite the name.
- cmd_data  input  24  command/data word to send.
- initiate  input  1  start request, sampled each clock.
- TX_C  output  1  UART transmit line, idle high.
- RX_C  input  1  UART receive line, asynchronous.
- rsp  output  16  last complete response; the first received byte is rsp[15:8].
- rsp_rdy  output  1  a complete response is held in rsp.

Behaviour:
- Frame format: 8N1. One start bit (0), 8 data bits LSB first, one stop bit (1). Every bit lasts exactly BAUD_DIV clocks.
- Reset values: TX_C=1, rsp=16'h0000, rsp_rdy=0; TX FSM in IDLE, RX FSM in IDLE, all counters 0.
- TX FSM states: IDLE, START, DATA, STOP.
- IDLE -> START:
  - Taken when initiate=1 at a clock edge.
  - On that edge, latch cmd_data into a 24-bit shift register, set byte count=0, clear rsp_rdy.
  - TX_C goes low on the following edge, so latency is 1 clock.
- START -> DATA: after BAUD_DIV clocks.
- DATA -> STOP: after 8 bits.
- STOP (BAUD_DIV clocks, TX_C=1):
  - If byte count<2, increment it and go to START for the next byte.
  - Otherwise go to IDLE.
- Byte order: cmd_data[23:16], then [15:8], then [7:0]. There is no idle gap between bytes beyond the stop bit.
- A full transmission is 30*BAUD_DIV clocks.
- initiate while TX is not IDLE is ignored: no relatch, no effect on rsp_rdy.
- RX input path: RX_C passes through a 2-flop synchroniser, initialised to 1.
- RX FSM states: IDLE, START, DATA, STOP.
- RX IDLE -> START: on a synchronised 1->0 transition.
- RX START: wait BAUD_DIV/2 clocks (integer division), then sample.
  - If the line is high (glitch), return to IDLE.
  - Otherwise go to DATA.
- RX DATA: sample every BAUD_DIV clocks, 8 samples, LSB first.
- RX STOP: sample after BAUD_DIV clocks.
  - Stop=1: the byte is valid.
  - Stop=0: framing error; discard the byte and leave the RX byte count unchanged.
  - Either way, return to IDLE.
- First valid byte (RX byte count 0): store it in a holding register and set count=1.
- Second valid byte:
  - Load rsp = {held byte, this byte} and set rsp_rdy=1 in the same edge.
  - Reset count to 0.
- rsp_rdy is a level signal. It stays 1 until the next accepted initiate, or reset.
- rsp holds its value until the next complete response overwrites it; it is not cleared by initiate.
- The accepted initiate also resets the RX byte count to 0, which discards a half-received response.
- RX runs independently of TX, so full-duplex is allowed.
- Simultaneous events:
  - If an accepted initiate and a second-byte completion fall on the same edge, the response wins: rsp loads and rsp_rdy=1.
  - The RX count still resets to 0 on that edge.
- Reset mid-frame: everything returns to reset values immediately. TX_C goes high asynchronously.
- Counters: a 16-bit baud counter and a 3-bit bit counter per direction, plus 2-bit TX and 1-bit RX byte counters.

Decomposition:
- Shared package cfg_uart_pkg holds:
  - the FSM state enum (IDLE/START/DATA/STOP, 2 bits);
  - the frame constants START_BIT=0, STOP_BIT=1, DATA_BITS=8;
  - the TX byte count of 3 and the RX byte count of 2.
- One sub-module is natural: uart_rx8.
  - Contents: synchroniser, RX FSM, and a one-clock byte_vld pulse with an 8-bit byte output.
  - The TX path and response assembly stay in cfg_master.

Test Plan:
1. Reset: hold rst_n=1 for 5 clocks -> TX_C=1, rsp=16'h0000, rsp_rdy=0. Mid-frame reset forces TX_C=1 at once.
2. Send: with BAUD_DIV=16, pulse initiate with cmd_data=24'hA5_3C_0F.
   - Decoded TX_C bytes are A5, 3C, 0F.
   - Each start bit is 16 clocks; the first falling edge is 1 clock after initiate; TX is idle again after 480 clocks.
3. Response: drive RX_C with bytes 12 then 34 at BAUD_DIV=16 -> rsp=16'h1234 and rsp_rdy=1 on the edge after the second stop-bit sample.
   - A following initiate clears rsp_rdy while rsp stays 16'h1234.
4. Busy ignore: a second initiate with 24'hFFFFFF during transmission -> the line still carries A5,3C,0F, and no fourth byte is sent.
5. Framing/glitch on RX:
   - A byte whose stop bit is 0 is dropped; after a later 56, 78 the result is rsp=16'h5678.
   - A 4-clock low pulse on RX_C produces no byte.
6. Loopback with an EEPROM-read-style command 24'h00_0002 against cbc_dig: a 16-bit rsp arrives with rsp_rdy=1 within 60*BAUD_DIV clocks.
